// File: rtl/day5_pkg.sv
// rtl/day5_pkg.sv - shared constants and phase encoding for the day-5 range engine
package day5_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 200;
  localparam int DEF_CNT_W = 32;

  // Phase encoding kept as plain constants so older tools can consume it.
  typedef logic [1:0] state_t;
  localparam state_t ST_LOAD  = 2'd0;
  localparam state_t ST_QUERY = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/day5_range_pe.sv
// rtl/day5_range_pe.sv - one range processing element: stored range plus one ID pipeline stage
module day5_range_pe
  import day5_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_load_en,
  input  logic [WIDTH-1:0] i_load_start,
  input  logic [WIDTH-1:0] i_load_end,
  input  logic             i_load_occ,
  output logic [WIDTH-1:0] o_start,
  output logic [WIDTH-1:0] o_end,
  output logic             o_occ,
  input  logic [WIDTH-1:0] i_id,
  input  logic             i_valid,
  input  logic             i_hit,
  output logic [WIDTH-1:0] o_id,
  output logic             o_valid,
  output logic             o_hit
);

  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             occ;
  } range_t;

  typedef struct packed {
    logic [WIDTH-1:0] id;
    logic             valid;
    logic             hit;
  } stage_t;

  range_t r_range;
  stage_t r_stage;
  logic   w_match;

  // An unloaded PE (occ=0) never matches, even though its bounds read as zero.
  assign w_match = i_valid & r_range.occ & (r_range.lo <= i_id) & (i_id <= r_range.hi);

  // Range storage: shifts along the chain on load, restart only drops occupancy.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_range <= '0;
    end else if (i_clear) begin
      r_range.occ <= 1'b0;
    end else if (i_load_en) begin
      r_range <= '{lo: i_load_start, hi: i_load_end, occ: i_load_occ};
    end
  end

  // ID stage: hit is sticky down the chain so overlapping ranges count once.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_stage <= '0;
    end else begin
      r_stage <= '{id: i_id, valid: i_valid, hit: i_hit | w_match};
    end
  end

  assign o_start = r_range.lo;
  assign o_end   = r_range.hi;
  assign o_occ   = r_range.occ;
  assign o_id    = r_stage.id;
  assign o_valid = r_stage.valid;
  assign o_hit   = r_stage.hit;

endmodule

// File: rtl/day5_range_engine.sv
// rtl/day5_range_engine.sv - streaming range-membership engine: phase FSM, handshakes, PE chain, counters
module day5_range_engine
  import day5_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_restart,
  input  logic                       i_range_valid,
  output logic                       o_range_ready,
  input  logic [WIDTH-1:0]           i_range_start,
  input  logic [WIDTH-1:0]           i_range_end,
  input  logic                       i_id_valid,
  output logic                       o_id_ready,
  input  logic [WIDTH-1:0]           i_id,
  input  logic                       i_id_last,
  output logic                       o_done,
  output logic [CNT_W-1:0]           o_total_fresh,
  output logic [CNT_W-1:0]           o_total_ids,
  output logic [$clog2(DEPTH+1)-1:0] o_ranges_loaded,
  output logic                       o_bad_range
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(DEPTH + 2);

  state_t           r_state;
  logic [DW-1:0]    r_drain_cnt;
  logic [CNT_W-1:0] r_fresh;
  logic [CNT_W-1:0] r_ids;
  logic [LW-1:0]    r_loaded;
  logic             r_bad;

  logic w_range_ready, w_id_ready, w_range_acc, w_id_acc;
  logic w_good, w_load_en, w_clear;

  // Index i is what PE i loads / receives; index DEPTH is what leaves the chain.
  logic [WIDTH-1:0] w_ld_start [DEPTH+1];
  logic [WIDTH-1:0] w_ld_end   [DEPTH+1];
  logic             w_ld_occ   [DEPTH+1];
  logic [WIDTH-1:0] w_pid      [DEPTH+1];
  logic             w_pv       [DEPTH+1];
  logic             w_ph       [DEPTH+1];
  logic             w_unused_tail;

  // Handshake readiness per phase; a range beat beats an ID beat in LOAD.
  always_comb begin
    w_range_ready = 1'b0;
    w_id_ready    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_range_ready = (r_loaded < LW'(DEPTH));
        w_id_ready    = ~i_range_valid;
      end
      ST_QUERY: w_id_ready = 1'b1;
      default: ;
    endcase
  end

  assign w_range_acc = i_range_valid & w_range_ready;
  assign w_id_acc    = i_id_valid & w_id_ready;
  assign w_good      = (i_range_start <= i_range_end);
  assign w_load_en   = w_range_acc & w_good;
  assign w_clear     = (r_state == ST_DONE) & i_restart;

  assign w_ld_start[0] = i_range_start;
  assign w_ld_end[0]   = i_range_end;
  assign w_ld_occ[0]   = 1'b1;
  assign w_pid[0]      = i_id;
  assign w_pv[0]       = w_id_acc;
  assign w_ph[0]       = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pe
      day5_range_pe #(.WIDTH(WIDTH)) u_pe (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (w_clear),
        .i_load_en    (w_load_en),
        .i_load_start (w_ld_start[gi]),
        .i_load_end   (w_ld_end[gi]),
        .i_load_occ   (w_ld_occ[gi]),
        .o_start      (w_ld_start[gi+1]),
        .o_end        (w_ld_end[gi+1]),
        .o_occ        (w_ld_occ[gi+1]),
        .i_id         (w_pid[gi]),
        .i_valid      (w_pv[gi]),
        .i_hit        (w_ph[gi]),
        .o_id         (w_pid[gi+1]),
        .o_valid      (w_pv[gi+1]),
        .o_hit        (w_ph[gi+1])
      );
    end
  endgenerate

  // The range shifted out of the last PE and the exiting ID value are discarded.
  assign w_unused_tail = ^{w_ld_start[DEPTH], w_ld_end[DEPTH], w_ld_occ[DEPTH], w_pid[DEPTH]};

  // Phase FSM; DRAIN lasts DEPTH+1 cycles so the last ID has reached the counters.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_LOAD;
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= '0;
      case (r_state)
        ST_LOAD:  if (w_id_acc) r_state <= i_id_last ? ST_DRAIN : ST_QUERY;
        ST_QUERY: if (w_id_acc && i_id_last) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (r_drain_cnt == DW'(DEPTH)) r_state <= ST_DONE;
          else r_drain_cnt <= r_drain_cnt + DW'(1);
        end
        default:  if (i_restart) r_state <= ST_LOAD;
      endcase
    end
  end

  // Range count, sticky bad-range flag and the result counters at the chain exit.
  always_ff @(posedge i_clock) begin
    if (i_reset || w_clear) begin
      r_loaded <= '0;
      r_bad    <= 1'b0;
      r_ids    <= '0;
      r_fresh  <= '0;
    end else begin
      if (w_load_en) r_loaded <= r_loaded + LW'(1);
      if (w_range_acc && !w_good) r_bad <= 1'b1;
      if (w_pv[DEPTH]) r_ids <= r_ids + CNT_W'(1);
      if (w_pv[DEPTH] && w_ph[DEPTH]) r_fresh <= r_fresh + CNT_W'(1);
    end
  end

  assign o_range_ready   = w_range_ready;
  assign o_id_ready      = w_id_ready;
  assign o_done          = (r_state == ST_DONE);
  assign o_total_fresh   = r_fresh;
  assign o_total_ids     = r_ids;
  assign o_ranges_loaded = r_loaded;
  assign o_bad_range     = r_bad;

endmodule

// File: tb/tb_day5_range_engine.sv
// tb/tb_day5_range_engine.sv - directed self-checking bench for day5_range_engine
module tb_day5_range_engine;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, restart;
  logic        range_valid, range_ready;
  logic [63:0] range_start, range_end;
  logic        id_valid, id_ready, id_last;
  logic [63:0] id;
  logic        done, bad_range;
  logic [31:0] total_fresh, total_ids;
  logic [2:0]  ranges_loaded;

  int tests = 0;
  int fails = 0;

  day5_range_engine #(.WIDTH(64), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .i_clock         (clock),
    .i_reset         (reset),
    .i_restart       (restart),
    .i_range_valid   (range_valid),
    .o_range_ready   (range_ready),
    .i_range_start   (range_start),
    .i_range_end     (range_end),
    .i_id_valid      (id_valid),
    .o_id_ready      (id_ready),
    .i_id            (id),
    .i_id_last       (id_last),
    .o_done          (done),
    .o_total_fresh   (total_fresh),
    .o_total_ids     (total_ids),
    .o_ranges_loaded (ranges_loaded),
    .o_bad_range     (bad_range)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_range(input logic [63:0] s, input logic [63:0] e);
    int n = 0;
    @(posedge clock); #1;
    range_valid = 1'b1; range_start = s; range_end = e;
    @(negedge clock);
    while (!range_ready && n < 20) begin @(negedge clock); n++; end
    check("range_accept", n < 20, 1);
    @(posedge clock); #1;
    range_valid = 1'b0;
  endtask

  task automatic send_id(input logic [63:0] v, input logic last);
    int n = 0;
    @(posedge clock); #1;
    id_valid = 1'b1; id = v; id_last = last;
    @(negedge clock);
    while (!id_ready && n < 20) begin @(negedge clock); n++; end
    check("id_accept", n < 20, 1);
    @(posedge clock); #1;
    id_valid = 1'b0; id_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clock);
    while (!done && n < 40) begin @(negedge clock); n++; end
    check("done_reached", done, 1);
  endtask

  task automatic do_restart();
    @(posedge clock); #1 restart = 1'b1;
    @(posedge clock); #1 restart = 1'b0;
    @(negedge clock);
    check("restart_done", done, 0);
    check("restart_ids", total_ids, 0);
    check("restart_fresh", total_fresh, 0);
    check("restart_loaded", ranges_loaded, 0);
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0;
    range_valid = 1'b0; range_start = '0; range_end = '0;
    id_valid = 1'b0; id = '0; id_last = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_done", done, 0);
    check("rst_fresh", total_fresh, 0);
    check("rst_ids", total_ids, 0);
    check("rst_loaded", ranges_loaded, 0);
    check("rst_bad", bad_range, 0);
    check("rst_range_ready", range_ready, 1);
    check("rst_id_ready", id_ready, 1);

    // No ranges: zeroed, unoccupied PEs must not match ID 0.
    send_id(0, 0); send_id(0, 0); send_id(5, 1);
    wait_done();
    check("empty_fresh", total_fresh, 0);
    check("empty_ids", total_ids, 3);
    do_restart();

    // Basic set with overlapping ranges.
    send_range(3, 5); send_range(10, 14); send_range(16, 20); send_range(12, 18);
    @(negedge clock);
    check("basic_loaded", ranges_loaded, 4);
    check("basic_full_ready", range_ready, 0);
    send_id(1, 0); send_id(5, 0); send_id(8, 0);
    send_id(11, 0); send_id(17, 0); send_id(32, 1);
    wait_done();
    check("basic_fresh", total_fresh, 3);
    check("basic_ids", total_ids, 6);
    check("basic_bad", bad_range, 0);
    check("done_range_ready", range_ready, 0);
    check("done_id_ready", id_ready, 0);
    do_restart();

    // Overflow: fifth range is refused.
    send_range(1, 1); send_range(2, 2); send_range(3, 3); send_range(4, 4);
    @(posedge clock); #1;
    range_valid = 1'b1; range_start = 5; range_end = 5;
    @(negedge clock);
    check("full_range_ready", range_ready, 0);
    check("full_id_blocked", id_ready, 0);
    @(posedge clock); #1 range_valid = 1'b0;
    @(negedge clock);
    check("full_loaded", ranges_loaded, 4);
    send_id(1, 0); send_id(5, 0); send_id(4, 1);
    wait_done();
    check("full_fresh", total_fresh, 2);
    check("full_ids", total_ids, 3);
    do_restart();

    // Bad range consumed but not stored.
    send_range(9, 2); send_range(7, 7);
    @(negedge clock);
    check("bad_flag", bad_range, 1);
    check("bad_loaded", ranges_loaded, 1);
    send_id(7, 0); send_id(8, 1);
    wait_done();
    check("bad_fresh", total_fresh, 1);
    check("bad_ids", total_ids, 2);
    do_restart();
    check("bad_cleared", bad_range, 0);

    // Range and ID together: range wins, then exact count latency.
    @(posedge clock); #1;
    range_valid = 1'b1; range_start = 10; range_end = 20;
    id_valid = 1'b1; id = 15; id_last = 1'b1;
    @(negedge clock);
    check("prio_range_ready", range_ready, 1);
    check("prio_id_ready", id_ready, 0);
    @(posedge clock); #1 range_valid = 1'b0;
    @(negedge clock);
    check("prio_id_ready_next", id_ready, 1);
    @(posedge clock); #1 id_valid = 1'b0; id_last = 1'b0;
    repeat (DEPTH - 1) @(posedge clock);
    @(negedge clock);
    check("lat_ids_before", total_ids, 0);
    @(posedge clock);
    @(negedge clock);
    check("lat_ids_at", total_ids, 1);
    check("lat_fresh_at", total_fresh, 1);
    wait_done();
    do_restart();

    // New run after restart: no carry-over.
    send_range(100, 200);
    send_id(150, 0); send_id(250, 1);
    wait_done();
    check("rerun_fresh", total_fresh, 1);
    check("rerun_ids", total_ids, 2);
    do_restart();

    // Reset mid-query discards everything.
    send_range(9, 2); send_range(1, 10);
    send_id(5, 0); send_id(6, 0);
    @(negedge clock);
    check("query_range_ready", range_ready, 0);
    check("query_id_ready", id_ready, 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("mid_done", done, 0);
    check("mid_fresh", total_fresh, 0);
    check("mid_ids", total_ids, 0);
    check("mid_loaded", ranges_loaded, 0);
    check("mid_bad", bad_range, 0);
    check("mid_range_ready", range_ready, 1);
    repeat (DEPTH + 2) @(negedge clock);
    check("mid_ids_later", total_ids, 0);
    check("mid_fresh_later", total_fresh, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/day5_range_engine.md
Name: day5_range_engine

Overview:
- Streaming range-membership engine: a chain of DEPTH processing elements, each holding one inclusive [start,end] range, tests a stream of IDs and counts those inside at least one range.
- Successor to the fixed-depth day-5 pipeline. Adds:
  - valid/ready handshakes on both input streams
  - per-PE occupancy, so unloaded PEs never match
  - an explicit phase FSM with drain and done
  - bad-range detection, ID total, and restart without reset
- Sits between the input-file streamer and the result/UART reporter.

Parameters:
- WIDTH, 64, bit width of range bounds and IDs
- DEPTH, 200, number of range PEs (maximum ranges held); at least 1
- CNT_W, 32, width of the fresh and total counters

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; returns the block to LOAD with everything cleared
- restart  in  1  in DONE: clear ranges and counters, go to LOAD; ignored in other states
- range_valid  in  1  range beat offered
- range_ready  out  1  range beat accepted when valid&ready
- range_start  in  WIDTH  inclusive lower bound
- range_end  in  WIDTH  inclusive upper bound
- id_valid  in  1  ID beat offered
- id_ready  out  1  ID beat accepted when valid&ready
- id  in  WIDTH  ID to classify
- id_last  in  1  marks the final ID of the stream
- done  out  1  high in DONE; counters are final
- total_fresh  out  CNT_W  IDs matched by at least one range
- total_ids  out  CNT_W  IDs accepted
- ranges_loaded  out  $clog2(DEPTH+1)  ranges currently stored
- bad_range  out  1  sticky: a range with start>end was offered and accepted

Behaviour:
- Reset values: state LOAD, all PE occupancy 0, all PE bounds 0, all counters 0, done 0, bad_range 0, pipeline valid bits 0. Outputs follow these values.
- FSM states: LOAD, QUERY, DRAIN, DONE.
- LOAD:
  - range_ready = (ranges_loaded < DEPTH).
  - Accepted range with start<=end: the PE chain shifts by one. PE0 takes the new range with occupancy 1; PE i+1 takes PE i's contents. ranges_loaded increments.
  - Accepted range with start>end: consumed, not stored, bad_range set. No shift, no count change.
  - id_ready = !range_valid, so a range wins when both streams are valid in the same cycle.
  - Accepted ID: go to QUERY. That ID enters the pipeline. If id_last is also high, go straight to DRAIN.
  - When ranges_loaded==DEPTH, range_ready stays low and IDs are still accepted.
- QUERY:
  - range_ready=0; range beats are ignored.
  - id_ready=1.
  - Accepted ID with id_last: go to DRAIN.
- DRAIN:
  - Both ready signals are 0.
  - Wait until the last accepted ID has updated the counters (drain counter of DEPTH+1 cycles), then go to DONE.
- DONE:
  - done=1; both ready signals 0; counters hold.
  - restart: go to LOAD next cycle, clearing occupancy, counters and bad_range; done drops.
- ID pipeline:
  - One stage per PE, carrying id, valid and hit.
  - Stage i output hit = hit_in | (valid & occ_i & start_i<=id & id<=end_i).
  - Comparisons are unsigned and inclusive.
  - Bubbles (valid=0) propagate and never count.
- Latency:
  - An ID accepted in cycle t is counted in total_fresh/total_ids visible in cycle t+DEPTH+1. total_ids increments on the valid bit leaving the last stage.
  - The DEPTH PE stages come first, then the counter register.
- Ranges are frozen for the whole QUERY phase. The pipeline never mixes range loads with IDs.
- Overlapping or duplicate ranges: each ID is still counted at most once.
- Empty range set: every ID is not fresh; total_ids still counts.
- Counters wrap modulo 2^CNT_W; no saturation.
- Reset asserted mid-query: pipeline contents are discarded; no partial count survives.
- restart outside DONE has no effect.

Decomposition:
- Package day5_pkg:
  - state enum (LOAD, QUERY, DRAIN, DONE)
  - PE-stage struct {id, valid, hit}
  - range struct {start, end, occ}, widths parameterised via the instantiating module
- One sub-module: day5_range_pe.
  - Holds the range and occupancy.
  - Shifts on load enable, clears on clear.
  - Registers the ID stage.
- Top level holds the FSM, the handshake logic, the drain counter and the counters.

Test Plan:
- Ranges 3-5, 10-14, 16-20, 12-18; IDs 1,5,8,11,17,32 with id_last on 32 -> done, total_fresh=3, total_ids=6, bad_range=0.
- DEPTH=4: offer 5 ranges -> range_ready low after the 4th and ranges_loaded=4. IDs are still accepted and match only the first 4 ranges.
- Range start=9,end=2 followed by range 7-7; IDs 7,8 -> bad_range=1, ranges_loaded=1, total_fresh=1.
- No ranges; IDs 0,0,5 (last) -> total_fresh=0, total_ids=3. ID 0 must not match unoccupied zeroed PEs.
- range_valid and id_valid high together in LOAD -> the range is accepted and id_ready=0 that cycle. The ID is taken the next cycle. Count appears exactly DEPTH+1 cycles after acceptance.
- After done, pulse restart and load a new set 100-200 with IDs 150,250 (last) -> total_fresh=1, total_ids=2. No carry-over from the previous run. Repeat with reset asserted mid-QUERY -> all outputs return to reset values.
